// File: rtl/multicycle_cla_adder.sv
// multicycle_cla_adder
//
// Sequential adder/subtractor. Each BUSY cycle handles one CHUNK-bit slice,
// starting with the least significant slice. Inside a slice every carry comes
// from group generate/propagate look-ahead. The carry out of each slice is
// registered and becomes the carry into the next slice.
//
// Handshake: the design accepts an operation on a rising edge where start=1
// and ready=1 (state IDLE). Once accepted, the operands are captured and start
// is ignored until ready returns high. done pulses for exactly one cycle when
// sum/cout/ovf take a new result, and those outputs hold until the next
// completion or reset.
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request to begin an operation
//   a, b   in   WIDTH-bit operands
//   cin    in   carry-in (add) / borrow-in (subtract)
//   sub    in   0 = a + b + cin, 1 = a - b - cin
//   ready  out  IDLE: a start will be accepted
//   busy   out  BUSY: slices are being computed
//   done   out  DONE: one-cycle pulse, new result valid
//   sum    out  last completed result
//   cout   out  raw carry out of the MSB (subtract: 1 = no borrow)
//   ovf    out  signed overflow of the last completed result
module multicycle_cla_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;      // already inverted for subtract
    logic [WIDTH-1:0] work;       // partial result, never visible on sum
    logic             carry;      // carry into the current slice
    logic [IDXW-1:0]  idx;
    logic             last;

    logic [CHUNK-1:0] sa, sb, g, p, s;
    logic [CHUNK:0]   c;
    logic             term;
    logic [WIDTH-1:0] result;

    assign last = (idx == IDXW'(NCHUNK - 1));

    // Slice datapath. Each c[i+1] is built directly from g/p and the slice
    // carry-in (sum-of-products look-ahead form), so no carry depends on the
    // carry of the bit below it.
    always_comb begin
        sa     = a_reg[int'(idx) * CHUNK +: CHUNK];
        sb     = b_reg[int'(idx) * CHUNK +: CHUNK];
        g      = sa & sb;
        p      = sa ^ sb;
        c      = '0;
        term   = 1'b0;
        c[0]   = carry;
        for (int i = 0; i < CHUNK; i++) begin
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i+1] = c[i+1] | term;
            end
            term = carry;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            c[i+1] = c[i+1] | term;
        end
        s      = p ^ c[CHUNK-1:0];
        result = work;
        result[int'(idx) * CHUNK +: CHUNK] = s;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and status outputs
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, slice stepping and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            work  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                a_reg <= a;
                b_reg <= sub ? ~b : b;
                carry <= cin ^ sub;   // subtract: a + ~b + 1 - cin
                idx   <= '0;
                work  <= '0;
            end else if (state == BUSY) begin
                work  <= result;
                carry <= c[CHUNK];
                if (last) begin
                    idx  <= '0;
                    sum  <= result;
                    cout <= c[CHUNK];
                    ovf  <= c[CHUNK] ^ c[CHUNK-1];
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/multicycle_cla_adder.md
MULTICYCLE_CLA_ADDER -- requirements
Module: multicycle_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per cycle by one carry-look-ahead group; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin an operation.
REQ-006 SHALL have port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry-in for add, borrow-in for subtract.
REQ-009 SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-010 SHALL have port ready  output  1  high when a start will be accepted.
REQ-011 SHALL have port busy  output  1  high while chunks are being computed.
REQ-012 SHALL have port done  output  1  one-cycle pulse: new result valid.
REQ-013 SHALL have port sum  output  WIDTH  last completed result.
REQ-014 SHALL have port cout  output  1  carry-out of last completed result.
REQ-015 SHALL have port ovf  output  1  signed overflow of last completed result.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE; ready = (IDLE), busy = (BUSY), done = (DONE).
REQ-017 SHALL accept start only in IDLE: on that edge, latch a, effective B = sub ? ~b : b, c0 = cin XOR sub, and chunk index = 0; state goes to BUSY.
REQ-018 SHALL ignore start in BUSY and DONE, with no effect on latched operands or outputs.
REQ-019 SHALL process exactly one CHUNK-bit slice per BUSY cycle, LSB slice first, using group generate/propagate look-ahead, not a ripple chain across the chunk.
REQ-020 SHALL register the carry out of each slice as the carry into the next slice.
REQ-021 SHALL write each slice result into an internal working register; sum, cout and ovf SHALL NOT show partial results.
REQ-022 SHALL, on the edge that computes slice NCHUNK-1, load sum, cout and ovf from the final result and go to DONE.
REQ-023 SHALL return from DONE to IDLE after exactly one cycle; done is high for that one cycle only.
REQ-024 SHALL compute, modulo 2^WIDTH: add gives a + b + cin; subtract gives a - b - cin.
REQ-025 SHALL set cout = raw carry out of the MSB; for subtract, cout = 1 means no borrow.
REQ-026 SHALL set ovf = carry into the MSB XOR carry out of the MSB.
REQ-027 SHALL time operations as follows: start sampled at edge 0, done high from edge NCHUNK to edge NCHUNK+1, ready high again after edge NCHUNK+1.
REQ-028 SHALL support CHUNK = WIDTH as legal: NCHUNK = 1, one BUSY cycle.
REQ-029 SHALL allow a start asserted in the cycle done is high to be ignored; start is accepted at the next edge where ready = 1.
REQ-030 SHALL hold sum, cout and ovf stable from completion until the next completion or reset.

Reset
REQ-031 SHALL, when rst is asserted, immediately force: state IDLE, ready = 1, busy = 0, done = 0, sum = 0, cout = 0, ovf = 0, chunk index = 0, working carry = 0.
REQ-032 SHALL, when rst is asserted mid-operation, abandon the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-033 SHALL check: a=18, b=2, cin=0, sub=0, start -> done exactly 4 cycles after the start edge, sum=20, cout=0, ovf=0; busy high for exactly 4 cycles.
REQ-034 SHALL check: a=16'hFFFF, b=0, cin=1, sub=0 -> sum=0, cout=1, ovf=0; then a=16'h7FFF, b=1, cin=0 -> sum=16'h8000, cout=0, ovf=1.
REQ-035 SHALL check: a=100, b=29, cin=0, sub=1 -> sum=71, cout=1; then a=29, b=100, cin=1, sub=1 -> sum=16'hFFB8 (-72), cout=0, ovf=0.
REQ-036 SHALL check: start=1 with new operands asserted on every BUSY cycle -> first result unchanged (19+24+1 = 44), exactly one done pulse, ready low throughout.
REQ-037 SHALL check: rst pulsed after 2 BUSY cycles -> all outputs 0, no done pulse, ready=1; the following 128+0+0 operation yields sum=128.
REQ-038 SHALL check: with CHUNK=16, a=16'hFFFF, b=16'hFFFF, cin=1 -> done 1 cycle after the start edge, sum=16'hFFFF, cout=1.
